// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and types for the write-back stage.
// Optional build macro used by wb_grf: GRF_TRACE_EN (write trace printing).
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] FUNCT_JALR = 6'h09;

    localparam int PKG_REG_AW = 5;

    typedef logic [PKG_REG_AW-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_LINK
    } wb_sel_t;

endpackage

// File: rtl/wb_sel_dec.sv
// Write-back source decode: maps the W-stage opcode/funct to a wb_sel_t.
module wb_sel_dec
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output wb_sel_t    sel
);

    // Loads take memory data, jal/jalr take the link address, everything else the ALU result.
    always_comb begin
        sel = WB_ALU;
        case (op)
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: sel = WB_MEM;
            OP_JAL:                              sel = WB_LINK;
            OP_SPECIAL: begin
                if (funct == FUNCT_JALR) begin
                    sel = WB_LINK;
                end
            end
            default:                             sel = WB_ALU;
        endcase
    end

endmodule

// File: rtl/wb_grf.sv
// W-stage write-back and 32x32 general register file with two bypassed read
// ports and a retired-instruction counter.
// Optional build macro: GRF_TRACE_EN prints one trace line per committed write.
module wb_grf
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_OFS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       W_inStr,
    input  logic [31:0]       W_PC,
    input  logic [REG_AW-1:0] W_writeReg,
    input  logic [DATA_W-1:0] W_dataOut,
    input  logic [DATA_W-1:0] W_result,
    input  logic [REG_AW-1:0] D_rs,
    input  logic [REG_AW-1:0] D_rt,
    output logic [DATA_W-1:0] D_rsData,
    output logic [DATA_W-1:0] D_rtData,
    output logic [DATA_W-1:0] W_writeData,
    output logic              W_we,
    output logic [31:0]       instret
);

    localparam int NREGS = 2 ** REG_AW;

    wb_sel_t           sel;
    logic [31:0]       link_addr;
    logic [DATA_W-1:0] regs [NREGS];
    logic [31:0]       instret_q;

    wb_sel_dec u_dec (
        .op    (W_inStr[31:26]),
        .funct (W_inStr[5:0]),
        .sel   (sel)
    );

    assign link_addr = W_PC + 32'(LINK_OFS);
    assign W_we      = (W_inStr != '0) && (W_writeReg != '0);
    assign instret   = instret_q;

    // Select the value committed (and forwarded) this cycle.
    always_comb begin
        W_writeData = W_result;
        case (sel)
            WB_MEM:  W_writeData = W_dataOut;
            WB_LINK: W_writeData = DATA_W'(link_addr);
            default: W_writeData = W_result;
        endcase
    end

    // Register array: async clear, one write per edge; entry 0 is never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (W_we) begin
            regs[W_writeReg] <= W_writeData;
        end
    end

    // Retired-instruction counter: counts every non-bubble, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_q <= '0;
        end else if (W_inStr != '0) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    // Read port 1: index 0 reads zero, then same-cycle bypass, then stored value.
    always_comb begin
        D_rsData = regs[D_rs];
        if (D_rs == '0) begin
            D_rsData = '0;
        end else if (W_we && (D_rs == W_writeReg)) begin
            D_rsData = W_writeData;
        end
    end

    // Read port 2: same rule as port 1.
    always_comb begin
        D_rtData = regs[D_rt];
        if (D_rt == '0) begin
            D_rtData = '0;
        end else if (W_we && (D_rt == W_writeReg)) begin
            D_rtData = W_writeData;
        end
    end

`ifdef GRF_TRACE_EN
    // Write trace; $strobe defers printing until after the nonblocking update.
    always_ff @(posedge clk) begin
        if (reset && W_we) begin
            $strobe("@%h: $%d <= %h", W_PC, W_writeReg, W_writeData);
        end
    end
`endif

endmodule
